// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with flush, sticky overflow/underflow flags and optional first-word-fall-through read port.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); writes when full and reads when empty are dropped and flagged.
module fifo_sync_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    input  logic             flush,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);
    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] C_DEPTH  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] C_AFULL  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] C_AEMPTY = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] C_ONE    = (ASIZE+1)'(1);

    if (ASIZE < 1 || AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_params
        $error("fifo_sync_param: illegal ASIZE / AFULL_TH / AEMPTY_TH combination");
    end

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Acceptance uses flags decoded from the count register, so full+read rejects the write this cycle.
    assign w_wr_acc = winc && !wfull  && !flush;
    assign w_rd_acc = rinc && !rempty && !flush;

    assign wfull         = (r_count == C_DEPTH);
    assign rempty        = (r_count == '0);
    assign walmost_full  = (r_count >= C_AFULL);
    assign ralmost_empty = (r_count <= C_AEMPTY);
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + C_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A fresh error condition outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && wfull && !flush) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc && rempty && !flush) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata = r_mem[r_rptr[ASIZE-1:0]];
    end else begin : g_regread
        logic [DSIZE-1:0] r_rdata;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata <= '0;
            end else if (w_rd_acc) begin
                r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
            end
        end

        assign rdata = r_rdata;
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised and directed bench for fifo_sync_param, driving a registered-read and an FWFT instance in lockstep.
// A queue-based reference model predicts occupancy, flags and read data for both instances.
module tb_fifo_sync_param;
    localparam int DSIZE     = 8;
    localparam int ASIZE     = 2;
    localparam int DEPTH     = 1 << ASIZE;
    localparam int AFULL_TH  = 3;
    localparam int AEMPTY_TH = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic             flush;
    logic             clr_err;

    logic             wfull0, walmost_full0, rempty0, ralmost_empty0, overflow0, underflow0;
    logic             wfull1, walmost_full1, rempty1, ralmost_empty1, overflow1, underflow1;
    logic [DSIZE-1:0] rdata0, rdata1;
    logic [ASIZE:0]   count0, count1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DSIZE-1:0] mq[$];
    logic [DSIZE-1:0] q0[$];
    logic [DSIZE-1:0] q1[$];
    bit               ov_m = 1'b0;
    bit               un_m = 1'b0;
    logic [DSIZE-1:0] exp0;
    bit               pend0 = 1'b0;

    fifo_sync_param #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull0), .walmost_full(walmost_full0),
        .rinc(rinc), .rdata(rdata0), .rempty(rempty0), .ralmost_empty(ralmost_empty0), .count(count0),
        .flush(flush), .clr_err(clr_err), .overflow(overflow0), .underflow(underflow0)
    );

    fifo_sync_param #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull1), .walmost_full(walmost_full1),
        .rinc(rinc), .rdata(rdata1), .rempty(rempty1), .ralmost_empty(ralmost_empty1), .count(count1),
        .flush(flush), .clr_err(clr_err), .overflow(overflow1), .underflow(underflow1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int c;
        c = mq.size();
        chk("count0", 32'(count0), c);
        chk("count1", 32'(count1), c);
        chk("wfull0", 32'(wfull0), 32'(c == DEPTH));
        chk("wfull1", 32'(wfull1), 32'(c == DEPTH));
        chk("rempty0", 32'(rempty0), 32'(c == 0));
        chk("rempty1", 32'(rempty1), 32'(c == 0));
        chk("walmost_full0", 32'(walmost_full0), 32'(c >= AFULL_TH));
        chk("walmost_full1", 32'(walmost_full1), 32'(c >= AFULL_TH));
        chk("ralmost_empty0", 32'(ralmost_empty0), 32'(c <= AEMPTY_TH));
        chk("ralmost_empty1", 32'(ralmost_empty1), 32'(c <= AEMPTY_TH));
        chk("overflow0", 32'(overflow0), 32'(ov_m));
        chk("overflow1", 32'(overflow1), 32'(ov_m));
        chk("underflow0", 32'(underflow0), 32'(un_m));
        chk("underflow1", 32'(underflow1), 32'(un_m));
    endtask

    // Reference model: a plain queue of stored words plus two sticky bits.
    task automatic model_update();
        bit full;
        bit empty;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (flush) begin
            mq.delete();
            q0.delete();
            q1.delete();
        end else begin
            if (rinc && !empty) mq.delete(0);
            if (winc && !full) begin
                mq.push_back(wdata);
                q0.push_back(wdata);
                q1.push_back(wdata);
            end
        end
        if (winc && full && !flush) ov_m = 1'b1;
        else if (clr_err) ov_m = 1'b0;
        if (rinc && empty && !flush) un_m = 1'b1;
        else if (clr_err) un_m = 1'b0;
    endtask

    task automatic step(input bit w, input logic [DSIZE-1:0] d, input bit r,
                        input bit fl = 1'b0, input bit ce = 1'b0);
        winc = w; wdata = d; rinc = r; flush = fl; clr_err = ce;
        @(negedge clk);
        check_state();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (mq.size() > 0) step(1'b0, '0, 1'b1);
    endtask

    // Monitor: a pop is presented whenever rinc meets a non-empty FIFO outside flush.
    always @(negedge clk) begin
        if (pend0) begin
            chk("rdata_fwft0", 32'(rdata0), 32'(exp0));
            pend0 = 1'b0;
        end
        if (rst_n && rinc && !rempty0 && !flush) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb0_pop: dut0 presented data, expected no data queued at %0t", $time);
            end else begin
                exp0  = q0.pop_front();
                pend0 = 1'b1;
            end
        end
        if (rst_n && rinc && !rempty1 && !flush) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb1_pop: dut1 presented data 0x%0h, expected no data queued at %0t", rdata1, $time);
            end else begin
                chk("rdata_fwft1", 32'(rdata1), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; winc = 1'b0; wdata = '0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("rdata0_reset", 32'(rdata0), 32'h0);
        rst_n = 1'b1;

        // Fill then drain in order, crossing the almost-full and full thresholds.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Full with simultaneous read and write, then clear the sticky flag.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Empty with simultaneous read and write.
        drain();
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Steady state at occupancy two across pointer wrap.
        drain();
        step(1'b1, 8'hC0, 1'b0);
        step(1'b1, 8'hC1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Flush wins over a concurrent write.
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with data and an error flag pending.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        winc = 1'b1; wdata = 8'h99; rinc = 1'b1;
        rst_n = 1'b0;
        #1;
        mq.delete(); q0.delete(); q1.delete();
        ov_m = 1'b0; un_m = 1'b0; pend0 = 1'b0;
        check_state();
        chk("rdata0_async_reset", 32'(rdata0), 32'h0);
        winc = 1'b0; rinc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Randomised traffic with occasional flush and error clear.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
        end
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
